// File: rtl/cpu_defs_pkg.sv
// Shared fetch-stage definitions: reset vector, stall-vector indices and the
// next-PC source encoding used by the PC generator and its selector.
package cpu_defs;

    localparam int          DEFAULT_ADDR_W = 32;
    localparam logic [31:0] PC_RESET_VEC   = 32'hBFC0_0000;
    localparam int          STALL_IF       = 0;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_EXC    = 3'd1,
        SEL_STALL  = 3'd2,
        SEL_BRANCH = 3'd3,
        SEL_PEND   = 3'd4,
        SEL_SEQ    = 3'd5
    } pc_sel_e;

    function automatic logic word_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_gen_next_pc_mux.sv
// Combinational priority selector for the fetch PC and the pending-redirect latch.
// Priority: disabled hold, exception/ERET, stall (latch branch), live branch, pending, sequential.
module next_pc_mux
    import cpu_defs::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int INC    = 4
) (
    input  logic              ce,
    input  logic              stall_if,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pend_valid,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic [ADDR_W-1:0] next_pc,
    output logic              next_pend_valid,
    output logic [ADDR_W-1:0] next_pend_addr
);

    pc_sel_e sel_s;

    // Pick the PC source by priority; a flush wins even over a stall.
    always_comb begin
        sel_s = SEL_HOLD;
        if (!ce) begin
            sel_s = SEL_HOLD;
        end else if (exc_req) begin
            sel_s = SEL_EXC;
        end else if (stall_if) begin
            sel_s = SEL_STALL;
        end else if (branch_req) begin
            sel_s = SEL_BRANCH;
        end else if (pend_valid) begin
            sel_s = SEL_PEND;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    // Produce the next register values for the chosen source.
    always_comb begin
        next_pc         = pc;
        next_pend_valid = pend_valid;
        next_pend_addr  = pend_addr;
        case (sel_s)
            SEL_HOLD: begin
                next_pc = pc;
            end
            SEL_EXC: begin
                next_pc         = exc_addr;
                next_pend_valid = 1'b0;
            end
            SEL_STALL: begin
                if (branch_req) begin
                    next_pend_valid = 1'b1;
                    next_pend_addr  = branch_addr;
                end else begin
                    next_pend_valid = pend_valid;
                end
            end
            SEL_BRANCH: begin
                next_pc         = branch_addr;
                next_pend_valid = 1'b0;
            end
            SEL_PEND: begin
                next_pc         = pend_addr;
                next_pend_valid = 1'b0;
            end
            SEL_SEQ: begin
                next_pc = pc + ADDR_W'(INC);
            end
            default: begin
                next_pc = pc;
            end
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: holds PC, chip-enable, misalign flag
// and the pending-redirect latch; all next-state decisions live in next_pc_mux.
module pc_gen
    import cpu_defs::*;
#(
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
    parameter int                STALL_W   = 6,
    parameter int                INC       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branchF,
    input  logic [ADDR_W-1:0]  branchAddr,
    input  logic               excF,
    input  logic [ADDR_W-1:0]  excAddr,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               pc_misalign,
    output logic               pend_valid
);

    logic [ADDR_W-1:0] pc_r;
    logic              ce_r;
    logic              pc_misalign_r;
    logic              pend_valid_r;
    logic [ADDR_W-1:0] pend_addr_r;

    logic [ADDR_W-1:0] next_pc_s;
    logic              next_pend_valid_s;
    logic [ADDR_W-1:0] next_pend_addr_s;

    // Only the fetch-stage bit of the stall vector matters here.
    logic stall_unused_s;
    assign stall_unused_s = ^stall;

    next_pc_mux #(
        .ADDR_W(ADDR_W),
        .INC   (INC)
    ) u_next_pc_mux (
        .ce             (ce_r),
        .stall_if       (stall[STALL_IF]),
        .branch_req     (branchF),
        .branch_addr    (branchAddr),
        .exc_req        (excF),
        .exc_addr       (excAddr),
        .pc             (pc_r),
        .pend_valid     (pend_valid_r),
        .pend_addr      (pend_addr_r),
        .next_pc        (next_pc_s),
        .next_pend_valid(next_pend_valid_s),
        .next_pend_addr (next_pend_addr_s)
    );

    // State registers; reset also drops any latched redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_r          <= 1'b0;
            pc_r          <= RESET_VEC;
            pc_misalign_r <= word_misaligned(RESET_VEC[1:0]);
            pend_valid_r  <= 1'b0;
            pend_addr_r   <= '0;
        end else begin
            ce_r          <= 1'b1;
            pc_r          <= next_pc_s;
            pc_misalign_r <= word_misaligned(next_pc_s[1:0]);
            pend_valid_r  <= next_pend_valid_s;
            pend_addr_r   <= next_pend_addr_s;
        end
    end

    assign pc          = pc_r;
    assign ce          = ce_r;
    assign pc_misalign = pc_misalign_r;
    assign pend_valid  = pend_valid_r;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a transaction-level model predicts the state after
// each clock; a monitor pops predictions and compares them with the outputs.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        branchF;
    logic [31:0] branchAddr;
    logic        excF;
    logic [31:0] excAddr;
    logic [31:0] pc;
    logic        ce;
    logic        pc_misalign;
    logic        pend_valid;

    pc_gen dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .branchF    (branchF),
        .branchAddr (branchAddr),
        .excF       (excF),
        .excAddr    (excAddr),
        .pc         (pc),
        .ce         (ce),
        .pc_misalign(pc_misalign),
        .pend_valid (pend_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        mis;
        logic        pv;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: fetch enable, PC, and at most one waiting redirect.
    bit          m_ce = 1'b0;
    longint      m_pc = 64'hBFC0_0000;
    longint      m_pend[$];

    task automatic step(input bit r, input logic [5:0] st, input bit b, input logic [31:0] ba,
                        input bit e, input logic [31:0] ea);
        exp_t x;
        @(negedge clk);
        rst = r; stall = st; branchF = b; branchAddr = ba; excF = e; excAddr = ea;
        if (r) begin
            m_ce = 1'b0;
            m_pc = 64'hBFC0_0000;
            m_pend.delete();
        end else if (!m_ce) begin
            m_ce = 1'b1;
        end else if (e) begin
            m_pc = longint'(ea);
            m_pend.delete();
        end else if (st[0]) begin
            if (b) begin
                m_pend.delete();
                m_pend.push_back(longint'(ba));
            end
        end else if (b) begin
            m_pc = longint'(ba);
            m_pend.delete();
        end else if (m_pend.size() > 0) begin
            m_pc = m_pend.pop_front();
        end else begin
            m_pc = (m_pc + 4) % 64'h1_0000_0000;
        end
        x.pc  = m_pc[31:0];
        x.ce  = m_ce;
        x.mis = (m_pc % 4) != 0;
        x.pv  = m_pend.size() > 0;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one prediction is due just after each posedge that follows a step.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("ce", {31'd0, ce}, {31'd0, x.ce});
                check("pc", pc, x.pc);
                check("pc_misalign", {31'd0, pc_misalign}, {31'd0, x.mis});
                check("pend_valid", {31'd0, pend_valid}, {31'd0, x.pv});
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; stall = 6'd0; branchF = 1'b0; branchAddr = 32'd0;
        excF = 1'b0; excAddr = 32'd0;

        // Reset release and sequential fetch up to 0xBFC00010.
        for (int i = 0; i < 3; i++) step(1'b1, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 12 && !(m_ce && m_pc == 64'hBFC0_0010); i++) idle(1);
        step(1'b0, 6'd0, 1'b1, 32'hBFC0_0100, 1'b0, 32'd0);
        idle(2);

        // Branch under a four-cycle stall; the newer target wins.
        step(1'b0, 6'd0, 1'b1, 32'hBFC0_0020, 1'b0, 32'd0);
        step(1'b0, 6'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 6'd1, 1'b1, 32'h8000_1000, 1'b0, 32'd0);
        step(1'b0, 6'd1, 1'b1, 32'h8000_2000, 1'b0, 32'd0);
        step(1'b0, 6'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(2);

        // Exception with a simultaneous branch overrides stall and pending redirect.
        step(1'b0, 6'd1, 1'b1, 32'h8000_3000, 1'b0, 32'd0);
        step(1'b0, 6'd1, 1'b1, 32'h8000_4000, 1'b1, 32'hBFC0_0380);
        step(1'b0, 6'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(2);

        // Address wrap and misaligned target.
        step(1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        idle(2);
        step(1'b0, 6'd0, 1'b1, 32'h8000_0002, 1'b0, 32'd0);
        idle(2);

        // Reset while a redirect is pending; the target must never be fetched.
        step(1'b0, 6'd1, 1'b1, 32'h9000_0000, 1'b0, 32'd0);
        step(1'b1, 6'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(4);

        // Upper stall bits alone must not stall fetch.
        step(1'b0, 6'b111110, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 6'b101010, 1'b0, 32'd0, 1'b0, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) rb[1:0] = 2'b00;
            step($urandom_range(0, 63) == 0, 6'($urandom), $urandom_range(0, 3) == 0, ra,
                 $urandom_range(0, 11) == 0, rb);
        end
        idle(1);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-stage program-counter generator for the MIPS-style 5/6-stage pipeline; the next generation of the basic PC register.
- Adds three things the basic register lacks: a configurable reset vector, an exception/ERET redirect that overrides stall, and a pending-redirect latch so a branch resolved during a fetch stall is not lost.
- Drives the instruction SRAM address and chip-enable; sits between the hazard/stall controller and the instruction memory.

Parameters:
- ADDR_W, 32, PC/address width in bits (≥8).
- RESET_VEC, 32'hBFC0_0000, PC value after reset (low ADDR_W bits used).
- STALL_W, 6, width of the pipeline stall vector; bit 0 is the fetch-stage stall.
- INC, 4, sequential PC increment.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- stall  input  STALL_W  per-stage stall vector; only bit 0 is used here.
- branchF  input  1  branch/jump redirect request this cycle.
- branchAddr  input  ADDR_W  branch/jump target.
- excF  input  1  exception or ERET flush request.
- excAddr  input  ADDR_W  exception handler address or EPC.
- pc  output  ADDR_W  current fetch address (registered).
- ce  output  1  instruction-memory enable (registered).
- pc_misalign  output  1  registered; high while pc[1:0] != 0.
- pend_valid  output  1  registered; high while a branch redirect is latched and waiting (debug/verification visibility).

Behaviour:
- Reset (rst=1 at posedge):
  - ce<=0, pc<=RESET_VEC, pend_valid<=0, pend_addr<=0, pc_misalign<=RESET_VEC[1:0]!=0.
  - Reset mid-operation discards any pending redirect.
- ce:
  - ce<=1 on every posedge with rst=0, so ce rises exactly one cycle after rst deasserts.
  - While ce=0, pc holds RESET_VEC and all redirect inputs are ignored (nothing is latched).
- Next-PC selection when ce=1, evaluated in priority order each posedge:
  1. excF=1: pc<=excAddr and pend_valid<=0. This applies regardless of stall[0]; a flush overrides a stall.
  2. stall[0]=1:
     - pc holds.
     - If branchF=1: pend_valid<=1, pend_addr<=branchAddr. The newest branch overwrites an older pending one.
     - Otherwise pending state holds.
  3. stall[0]=0 and branchF=1: pc<=branchAddr, pend_valid<=0. A live branch beats a stale pending one.
  4. stall[0]=0 and pend_valid=1: pc<=pend_addr, pend_valid<=0.
  5. Otherwise: pc<=pc+INC, modulo 2^ADDR_W (0xFFFF_FFFC+4 -> 0x0000_0000, no flag).
- Misaligned redirects:
  - A redirect target with addr[1:0]!=0 is still loaded.
  - pc_misalign is computed from the new pc and updates in the same cycle as pc.
  - The AdEL exception is raised downstream, not here.
- Latency:
  - A redirect is visible on pc one cycle after the request cycle.
  - A pending redirect is visible one cycle after the cycle in which stall[0] falls.
- Stall bits other than bit 0 are ignored.
- No combinational path exists from any input to any output.

Decomposition:
- Shared package (cpu_defs): PC_RESET_VEC, STALL_IF index constant (=0), default ADDR_W.
- Sub-module next_pc_mux: purely combinational priority selector producing next_pc, next_pend_valid and next_pend_addr.
- pc_gen itself holds only the registers.

Test Plan:
- Reset release: rst=1 for 3 cycles, then 0 -> ce=0 and pc=0xBFC00000 during reset; ce=1 on the first posedge after release; pc=0xBFC00000 on the next posedge, then 0xBFC00004, 0xBFC00008.
- Branch not stalled: at pc=0xBFC00010 assert branchF=1, branchAddr=0xBFC00100 for 1 cycle -> pc=0xBFC00100 next cycle, then 0xBFC00104.
- Branch under stall:
  - Stimulus: stall[0]=1 for 4 cycles with pc=0xBFC00020; pulse branchF with 0x80001000 in cycle 2; pulse it again with 0x80002000 in cycle 3.
  - Required response: pc holds 0xBFC00020; pend_valid=1; after the stall drops, pc=0x80002000 and pend_valid=0.
- Exception overrides stall and pending:
  - Stimulus: stall[0]=1 with pend_valid=1; assert excF=1, excAddr=0xBFC00380, with branchF=1 in the same cycle.
  - Required response: pc=0xBFC00380, pend_valid=0; after the stall drops, pc increments to 0xBFC00384.
- Wrap and misalign:
  - Wrap: force pc=0xFFFFFFFC via branch -> next pc=0x00000000.
  - Misalign: branch to 0x80000002 -> pc_misalign=1 in the same cycle pc updates, then pc=0x80000006.
- Reset mid-stall: pend_valid=1 and stall[0]=1, assert rst for 1 cycle -> pend_valid=0, ce=0, pc=0xBFC00000; the pending target is never fetched.
